// File: rtl/envelope_generator.sv
// envelope_generator
// Linear ADSR envelope. A rising gate starts the attack. Falling gate starts the release.
// The amplitude moves by one step per rate period.
// The rate period for code c is (c+1) << RATE_SHIFT cycles.

module envelope_generator #(
    parameter int RATE_SHIFT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gate,
    input  logic [3:0] attack,
    input  logic [3:0] decay,
    input  logic [3:0] sustain,
    input  logic [3:0] release_code,   // release rate code
    output logic [7:0] amplitude,
    output logic [2:0] state,
    output logic       active
);

    localparam int CW = RATE_SHIFT + 4;

    // Low RATE_SHIFT bits all ones.
    // This makes (c << RATE_SHIFT) | LOW_ONES equal to P(c)-1 without any adder.
    localparam logic [CW-1:0] LOW_ONES = CW'((64'd1 << RATE_SHIFT) - 64'd1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    env_state_t    state_q, state_d;
    logic [7:0]    amp_q, amp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gate_q;

    logic          rise;
    logic          expire;
    logic [3:0]    rate_code;
    logic [CW-1:0] period_m1;
    logic [7:0]    s_level;

    assign rise      = gate & ~gate_q;
    assign s_level   = {sustain, sustain};          // sustain * 17
    assign period_m1 = (CW'(rate_code) << RATE_SHIFT) | LOW_ONES;

    // Pick the rate code that governs the current state. The code is sampled live.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first.
        // Otherwise a missed branch infers a latch.
        rate_code = 4'd0;
        case (state_q)
            ST_ATTACK:  rate_code = attack;
            ST_DECAY:   rate_code = decay;
            ST_RELEASE: rate_code = release_code;
            default:    rate_code = 4'd0;
        endcase
    end

    // The >= compare also expires at once when the rate code drops below the running count.
    assign expire = (cnt_q >= period_m1);

    // Next-state and next-amplitude logic. Gate events outrank the per-state rules.
    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        if (rise) begin
            state_d = ST_ATTACK;
        end else if (!gate && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                               state_q == ST_SUSTAIN)) begin
            state_d = ST_RELEASE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    amp_d = 8'd0;
                end
                ST_ATTACK: begin
                    if (amp_q == 8'hFF) begin
                        state_d = ST_DECAY;
                    end else if (expire) begin
                        amp_d = amp_q + 8'd1;
                        if (amp_d == 8'hFF) state_d = ST_DECAY;
                    end
                end
                ST_DECAY: begin
                    if (amp_q <= s_level) begin
                        state_d = ST_SUSTAIN;
                    end else if (expire) begin
                        amp_d = amp_q - 8'd1;
                        if (amp_d <= s_level) state_d = ST_SUSTAIN;
                    end
                end
                ST_SUSTAIN: begin
                    // A lowered sustain level sends us back down.
                    // A raised level is simply ignored.
                    if (amp_q > s_level) state_d = ST_DECAY;
                end
                ST_RELEASE: begin
                    if (amp_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else if (expire) begin
                        amp_d = amp_q - 8'd1;
                        if (amp_d == 8'd0) state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    amp_d   = 8'd0;
                end
            endcase
        end
    end

    // Period counter.
    // It restarts on any state change, a retrigger or an expiry.
    // It idles at zero while no stepping is possible.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (rise || state_d != state_q || expire ||
            state_q == ST_IDLE || state_q == ST_SUSTAIN) begin
            cnt_d = '0;
        end
    end

    // State, amplitude, counter and gate history registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments.
        // That way every register samples the pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            amp_q   <= 8'd0;
            cnt_q   <= '0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            amp_q   <= amp_d;
            cnt_q   <= cnt_d;
            gate_q  <= gate;
        end
    end

    assign amplitude = amp_q;
    assign state     = state_q;
    assign active    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_envelope_generator.sv
// tb_envelope_generator
// Directed scenarios with literal expectations, then randomized gate/rate activity.
// A timestamp-based reference model is compared against the DUT on every falling clock edge.

module tb_envelope_generator;

    localparam int RS        = 0;
    localparam int M_IDLE    = 0;
    localparam int M_ATTACK  = 1;
    localparam int M_DECAY   = 2;
    localparam int M_SUSTAIN = 3;
    localparam int M_RELEASE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       gate = 1'b0;
    logic [3:0] attack = 4'd0;
    logic [3:0] decay = 4'd0;
    logic [3:0] sustain = 4'd0;
    logic [3:0] release_code = 4'd0;
    logic [7:0] amplitude;
    logic [2:0] state;
    logic       active;

    int n_cmp = 0;
    int n_bad = 0;

    envelope_generator #(.RATE_SHIFT(RS)) dut (
        .clk          (clk),
        .rst          (rst),
        .gate         (gate),
        .attack       (attack),
        .decay        (decay),
        .sustain      (sustain),
        .release_code (release_code),
        .amplitude    (amplitude),
        .state        (state),
        .active       (active)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model.
    // m_mark is the edge at which the rate period last restarted.
    // A step is due once P edges have passed since then.
    int m_amp    = 0;
    int m_state  = M_IDLE;
    int m_gate_q = 0;
    int m_edge   = 0;
    int m_mark   = 0;

    task automatic model_step();
        int  prev, lvl, code, per;
        bit  rise, due, restart;
        m_edge++;
        if (rst) begin
            m_amp    = 0;
            m_state  = M_IDLE;
            m_gate_q = 0;
            m_mark   = m_edge;
            return;
        end
        prev    = m_state;
        restart = 1'b0;
        lvl     = int'(sustain) * 17;
        code    = (m_state == M_ATTACK) ? int'(attack) :
                  (m_state == M_DECAY)  ? int'(decay)  : int'(release_code);
        per     = (code + 1) * (1 << RS);
        due     = (m_edge - m_mark) >= per;
        rise    = gate && (m_gate_q == 0);
        if (rise) begin
            m_state = M_ATTACK;
            restart = 1'b1;
        end else if (!gate && m_state >= M_ATTACK && m_state <= M_SUSTAIN) begin
            m_state = M_RELEASE;
        end else if (m_state == M_ATTACK) begin
            if (m_amp == 255) m_state = M_DECAY;
            else if (due) begin
                m_amp   = m_amp + 1;
                restart = 1'b1;
                if (m_amp == 255) m_state = M_DECAY;
            end
        end else if (m_state == M_DECAY) begin
            if (m_amp <= lvl) m_state = M_SUSTAIN;
            else if (due) begin
                m_amp   = m_amp - 1;
                restart = 1'b1;
                if (m_amp <= lvl) m_state = M_SUSTAIN;
            end
        end else if (m_state == M_SUSTAIN) begin
            if (m_amp > lvl) m_state = M_DECAY;
        end else if (m_state == M_RELEASE) begin
            if (m_amp == 0) m_state = M_IDLE;
            else if (due) begin
                m_amp   = m_amp - 1;
                restart = 1'b1;
                if (m_amp == 0) m_state = M_IDLE;
            end
        end
        if (restart || m_state != prev) m_mark = m_edge;
        m_gate_q = gate ? 1 : 0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Continuous comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("model_amplitude", amplitude, m_amp);
        check("model_state", state, m_state);
        check("model_active", active, (m_state != M_IDLE) ? 1 : 0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until the model reaches a given state and amplitude.
    task automatic wait_model(input string name, input int st, input int amp, input int budget);
        int  i;
        logic reached;
        i = 0;
        while (!(m_state == st && m_amp == amp) && i < budget) begin
            @(negedge clk);
            i++;
        end
        reached = (m_state == st && m_amp == amp);
        check(name, reached, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with gate held high.
        rst = 1'b1; gate = 1'b1; attack = 4'd0; decay = 4'd0; sustain = 4'd8; release_code = 4'd0;
        tick(3);
        check("rst_amplitude", amplitude, 0);
        check("rst_state", state, 0);
        check("rst_active", active, 0);
        rst = 1'b0;

        // Full attack / decay / sustain with P=1, S=136.
        tick(1);
        check("ads_attack_entry_state", state, 1);
        check("ads_attack_entry_amp", amplitude, 0);
        tick(1);
        check("ads_first_step", amplitude, 1);
        tick(253);
        check("ads_amp_254", amplitude, 254);
        check("ads_still_attack", state, 1);
        tick(1);
        check("ads_peak_amp", amplitude, 255);
        check("ads_peak_state", state, 2);
        tick(118);
        check("ads_amp_137", amplitude, 137);
        check("ads_still_decay", state, 2);
        tick(1);
        check("ads_sustain_amp", amplitude, 136);
        check("ads_sustain_state", state, 3);
        tick(20);
        check("ads_hold_amp", amplitude, 136);
        check("ads_hold_state", state, 3);

        // Release with P=2.
        release_code = 4'd1; gate = 1'b0;
        tick(1);
        check("rel_entry_state", state, 4);
        check("rel_entry_amp", amplitude, 136);
        tick(1);
        check("rel_no_step_yet", amplitude, 136);
        tick(1);
        check("rel_first_step", amplitude, 135);
        tick(269);
        check("rel_amp_1", amplitude, 1);
        check("rel_still_release", state, 4);
        tick(1);
        check("rel_end_amp", amplitude, 0);
        check("rel_end_state", state, 0);
        check("rel_end_active", active, 0);

        // Retrigger from the release at amplitude 100.
        release_code = 4'd0; attack = 4'd0; sustain = 4'd8; gate = 1'b1;
        wait_model("retrig_reach_attack_120", M_ATTACK, 120, 400);
        gate = 1'b0;
        wait_model("retrig_reach_release_100", M_RELEASE, 100, 100);
        gate = 1'b1;
        tick(1);
        check("retrig_state", state, 1);
        check("retrig_amp_held", amplitude, 100);
        tick(1);
        check("retrig_amp_101", amplitude, 101);
        tick(1);
        check("retrig_amp_102", amplitude, 102);

        // Sustain level 15: the peak stays at 255.
        gate = 1'b0;
        wait_model("s15_back_to_idle", M_IDLE, 0, 400);
        sustain = 4'd15; attack = 4'd0; gate = 1'b1;
        tick(1);
        check("s15_attack_entry", state, 1);
        tick(255);
        check("s15_peak_state", state, 2);
        check("s15_peak_amp", amplitude, 255);
        tick(1);
        check("s15_sustain_state", state, 3);
        check("s15_sustain_amp", amplitude, 255);

        // Sustain lowered to 0: decay to zero, still active, then release to idle.
        sustain = 4'd0; decay = 4'd0;
        tick(1);
        check("s0_back_to_decay", state, 2);
        check("s0_decay_amp", amplitude, 255);
        tick(255);
        check("s0_sustain_state", state, 3);
        check("s0_sustain_amp", amplitude, 0);
        check("s0_sustain_active", active, 1);
        gate = 1'b0;
        tick(1);
        check("s0_release_state", state, 4);
        tick(1);
        check("s0_idle_state", state, 0);
        check("s0_idle_active", active, 0);

        // Live release-rate change mid-count.
        sustain = 4'd15; attack = 4'd0; gate = 1'b1;
        tick(257);
        check("live_sustain_state", state, 3);
        release_code = 4'd15; gate = 1'b0;
        tick(1);
        check("live_release_state", state, 4);
        tick(10);
        check("live_amp_before_change", amplitude, 255);
        release_code = 4'd0;
        tick(1);
        check("live_first_step", amplitude, 254);
        tick(1);
        check("live_second_step", amplitude, 253);
        tick(1);
        check("live_third_step", amplitude, 252);
        wait_model("live_back_to_idle", M_IDLE, 0, 400);

        // Randomized gate, rate and reset activity checked by the model.
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: gate = ~gate;
                3: begin
                    attack       = 4'($urandom_range(0, 15));
                    decay        = 4'($urandom_range(0, 15));
                    release_code = 4'($urandom_range(0, 15));
                end
                4: sustain = 4'($urandom_range(0, 15));
                default: begin
                    attack       = 4'($urandom_range(0, 3));
                    release_code = 4'($urandom_range(0, 3));
                end
            endcase
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 4));
            else tick($urandom_range(1, 200));
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                tick($urandom_range(1, 3));
                rst = 1'b0;
            end
        end

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
